// File: rtl/con_ff_pkg.sv
// Shared definitions for the conditional-branch unit: condition codes,
// FSM states and the branch-decision function.
package con_ff_pkg;

    localparam int COND_W = 4;

    typedef enum logic [COND_W-1:0] {
        COND_EQ     = 4'd0,
        COND_NE     = 4'd1,
        COND_GT     = 4'd2,
        COND_LT     = 4'd3,
        COND_GE     = 4'd4,
        COND_LE     = 4'd5,
        COND_ALWAYS = 4'd6,
        COND_NEVER  = 4'd7
    } cond_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    // Codes 8-15 are reserved and always resolve not taken.
    function automatic logic cond_reserved(input logic [COND_W-1:0] code);
        return code[COND_W-1];
    endfunction

    function automatic logic cond_taken(input logic [COND_W-1:0] code,
                                        input logic is_zero,
                                        input logic is_neg);
        logic t;
        t = 1'b0;
        case (code)
            COND_EQ:     t = is_zero;
            COND_NE:     t = !is_zero;
            COND_GT:     t = !is_zero && !is_neg;
            COND_LT:     t = is_neg;
            COND_GE:     t = !is_neg;
            COND_LE:     t = is_zero || is_neg;
            COND_ALWAYS: t = 1'b1;
            default:     t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/con_ff_if.sv
// Control-unit <-> branch-unit signal bundle. master = control unit,
// slave = con_ff_unit.
interface con_ff_if #(
    parameter int DATA_W = 32,
    parameter int IR_W   = 32,
    parameter int CNT_W  = 16
);
    logic [IR_W-1:0]   ir;
    logic [DATA_W-1:0] bus;
    logic              con_in;
    logic              branch_ack;
    logic              do_branch;
    logic              valid;
    logic              illegal;
    logic              overrun;
    logic [CNT_W-1:0]  taken_cnt;
    logic [CNT_W-1:0]  not_taken_cnt;

    modport master (
        output ir, bus, con_in, branch_ack,
        input  do_branch, valid, illegal, overrun, taken_cnt, not_taken_cnt
    );

    modport slave (
        input  ir, bus, con_in, branch_ack,
        output do_branch, valid, illegal, overrun, taken_cnt, not_taken_cnt
    );
endinterface

// File: rtl/con_ff_cmp.sv
// Zero/sign classifier for the operand; no subtractor needed since every
// condition is a comparison against zero.
module con_ff_cmp #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] bus,
    output logic              is_zero,
    output logic              is_neg
);
    assign is_zero = ~|bus;
    assign is_neg  = bus[DATA_W-1];
endmodule

// File: rtl/con_ff_unit.sv
// Registered conditional-branch unit: captures a branch decision on con_in and
// holds it until branch_ack. Statistics counters built only with BRANCH_STATS_EN.
module con_ff_unit
    import con_ff_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int IR_W     = 32,
    parameter int COND_LSB = 19,
    parameter int CNT_W    = 16
) (
    input logic     clk,
    input logic     clr,
    con_ff_if.slave bi
);
    logic              is_zero, is_neg;
    logic [COND_W-1:0] code;
    logic              taken, reserved, capture, overrun_set;
    state_e            state, state_nx;
    logic              do_branch_q, illegal_q, overrun_q;

    // Only the condition field of ir matters; the rest is intentionally ignored.
    logic unused_ir;
    assign unused_ir = ^bi.ir;

    assign code = bi.ir[COND_LSB +: COND_W];

    con_ff_cmp #(.DATA_W(DATA_W)) u_cmp (
        .bus     (bi.bus),
        .is_zero (is_zero),
        .is_neg  (is_neg)
    );

    always_comb begin
        taken       = cond_taken(code, is_zero, is_neg);
        reserved    = cond_reserved(code);
        capture     = bi.con_in;
        overrun_set = capture && (state == ST_HOLD) && !bi.branch_ack;
        state_nx    = state;
        if (capture)
            state_nx = ST_HOLD;
        else if (state == ST_HOLD && bi.branch_ack)
            state_nx = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (clr) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Decision and illegal flag persist after ack; consumers qualify with valid.
    always_ff @(posedge clk) begin
        if (clr) begin
            do_branch_q <= 1'b0;
            illegal_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (capture) begin
                do_branch_q <= taken;
                illegal_q   <= reserved;
            end
            if (overrun_set)
                overrun_q <= 1'b1;
        end
    end

    assign bi.do_branch = do_branch_q;
    assign bi.valid     = (state == ST_HOLD);
    assign bi.illegal   = illegal_q;
    assign bi.overrun   = overrun_q;

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] taken_q, not_taken_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            taken_q     <= '0;
            not_taken_q <= '0;
        end else if (capture) begin
            if (taken && taken_q != '1)
                taken_q <= taken_q + CNT_W'(1);
            if (!taken && not_taken_q != '1)
                not_taken_q <= not_taken_q + CNT_W'(1);
        end
    end

    assign bi.taken_cnt     = taken_q;
    assign bi.not_taken_cnt = not_taken_q;
`else
    assign bi.taken_cnt     = '0;
    assign bi.not_taken_cnt = '0;
`endif

endmodule

// File: tb/tb_con_ff_unit.sv
// Bench for con_ff_unit: an 8-bit/2-bit-counter instance and a default-width
// instance share control stimulus and are checked against a signed-arithmetic model.
module tb_con_ff_unit;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    con_ff_if #(.DATA_W(8),  .IR_W(32), .CNT_W(2))  if_a ();
    con_ff_if #(.DATA_W(32), .IR_W(32), .CNT_W(16)) if_b ();

    con_ff_unit #(.DATA_W(8), .IR_W(32), .COND_LSB(19), .CNT_W(2)) dut_a (
        .clk (clk),
        .clr (clr),
        .bi  (if_a)
    );

    con_ff_unit #(.DATA_W(32), .IR_W(32), .COND_LSB(19), .CNT_W(16)) dut_b (
        .clk (clk),
        .clr (clr),
        .bi  (if_b)
    );

    int n_chk = 0;
    int n_err = 0;

    // model state, index 0 = dut_a, 1 = dut_b
    bit e_valid[2], e_db[2], e_ill[2], e_ovr[2];
    int e_tk[2], e_nt[2];
    int cmax[2] = '{3, 65535};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit decide(input int code, input longint v);
        case (code)
            0:       return v == 0;
            1:       return v != 0;
            2:       return v > 0;
            3:       return v < 0;
            4:       return v >= 0;
            5:       return v <= 0;
            6:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model(input int i, input bit cin, input bit ack, input bit rst,
                         input int code, input longint v);
        bit t;
        if (rst) begin
            e_valid[i] = 0; e_db[i] = 0; e_ill[i] = 0; e_ovr[i] = 0;
            e_tk[i] = 0; e_nt[i] = 0;
        end else if (cin) begin
            if (e_valid[i] && !ack) e_ovr[i] = 1;
            t = decide(code, v);
            e_valid[i] = 1;
            e_db[i]    = t;
            e_ill[i]   = (code >= 8);
`ifdef BRANCH_STATS_EN
            if (t) e_tk[i] = (e_tk[i] < cmax[i]) ? e_tk[i] + 1 : e_tk[i];
            else   e_nt[i] = (e_nt[i] < cmax[i]) ? e_nt[i] + 1 : e_nt[i];
`endif
        end else if (ack) begin
            e_valid[i] = 0;
        end
    endtask

    task automatic check_all();
        chk("a_valid",   32'(if_a.valid),         32'(e_valid[0]));
        chk("a_do_br",   32'(if_a.do_branch),     32'(e_db[0]));
        chk("a_illegal", 32'(if_a.illegal),       32'(e_ill[0]));
        chk("a_overrun", 32'(if_a.overrun),       32'(e_ovr[0]));
        chk("a_tk_cnt",  32'(if_a.taken_cnt),     32'(e_tk[0]));
        chk("a_nt_cnt",  32'(if_a.not_taken_cnt), 32'(e_nt[0]));
        chk("b_valid",   32'(if_b.valid),         32'(e_valid[1]));
        chk("b_do_br",   32'(if_b.do_branch),     32'(e_db[1]));
        chk("b_illegal", 32'(if_b.illegal),       32'(e_ill[1]));
        chk("b_overrun", 32'(if_b.overrun),       32'(e_ovr[1]));
        chk("b_tk_cnt",  32'(if_b.taken_cnt),     32'(e_tk[1]));
        chk("b_nt_cnt",  32'(if_b.not_taken_cnt), 32'(e_nt[1]));
    endtask

    // One clock: drive, clock, update model, sample 1 time unit after the edge.
    task automatic step(input bit cin, input bit ack, input bit rst,
                        input int code, input logic [7:0] ba, input logic [31:0] bb);
        logic [31:0] irv;
        irv        = $urandom;
        irv[22:19] = 4'(code);
        clr            = rst;
        if_a.con_in    = cin;  if_b.con_in    = cin;
        if_a.branch_ack = ack; if_b.branch_ack = ack;
        if_a.ir        = irv;  if_b.ir        = irv;
        if_a.bus       = ba;   if_b.bus       = bb;
        @(posedge clk);
        model(0, cin, ack, rst, code, longint'($signed(ba)));
        model(1, cin, ack, rst, code, longint'($signed(bb)));
        #1;
        check_all();
    endtask

    function automatic logic [31:0] sx(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

    logic [7:0] dvals [3] = '{8'd0, 8'd7, 8'hFC};

    initial begin
        logic [7:0]  ra;
        logic [31:0] rb;
        clr = 1'b1;
        if_a.con_in = 0; if_a.branch_ack = 0; if_a.ir = '0; if_a.bus = '0;
        if_b.con_in = 0; if_b.branch_ack = 0; if_b.ir = '0; if_b.bus = '0;
        for (int i = 0; i < 2; i++) begin
            e_valid[i] = 0; e_db[i] = 0; e_ill[i] = 0; e_ovr[i] = 0;
            e_tk[i] = 0; e_nt[i] = 0;
        end

        // reset, then ack alone in IDLE
        step(0, 0, 1, 0, 8'h00, 32'h0);
        step(0, 0, 1, 0, 8'h00, 32'h0);
        step(0, 0, 0, 0, 8'h00, 32'h0);
        step(0, 1, 0, 0, 8'h00, 32'h0);

        // every legal code against 0, 7, -4
        for (int c = 0; c < 8; c++)
            for (int k = 0; k < 3; k++) begin
                step(1, 0, 0, c, dvals[k], sx(dvals[k]));
                step(0, 1, 0, 0, 8'h55, 32'h5555);
                step(0, 0, 0, 0, 8'h00, 32'h0);
            end

        // reserved code, then clean capture
        step(1, 0, 0, 12, 8'd7, 32'd7);
        step(0, 1, 0, 0, 8'd0, 32'd0);
        step(1, 0, 0, 0, 8'd0, 32'd0);
        step(0, 1, 0, 0, 8'd0, 32'd0);

        // overrun, then capture-with-ack does not overrun
        step(1, 0, 0, 6, 8'd1, 32'd1);
        step(1, 0, 0, 7, 8'd1, 32'd1);
        step(0, 1, 0, 0, 8'd0, 32'd0);
        step(0, 0, 1, 0, 8'd0, 32'd0);
        step(1, 0, 0, 2, 8'd3, 32'd3);
        step(1, 1, 0, 3, 8'hF0, 32'hFFFF_FFF0);
        step(0, 1, 0, 0, 8'd0, 32'd0);

        // clr beats a same-cycle capture in HOLD
        step(1, 0, 0, 6, 8'd0, 32'd0);
        step(1, 0, 1, 6, 8'd0, 32'd0);

        // counter saturation, most-negative operand
        for (int n = 0; n < 5; n++) begin
            step(1, 0, 0, 6, 8'd9, 32'd9);
            step(0, 1, 0, 0, 8'd0, 32'd0);
        end
        step(1, 0, 0, 3, 8'h80, 32'h8000_0000);
        step(0, 1, 0, 0, 8'd0, 32'd0);
        for (int n = 0; n < 4; n++)
            step(1, 1, 0, 7, 8'd1, 32'd1);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            ra = (($urandom % 4) == 0) ? 8'd0  : 8'($urandom);
            rb = (($urandom % 4) == 0) ? 32'd0 : $urandom;
            step(($urandom % 10) < 4, ($urandom % 10) < 4, ($urandom % 40) == 0,
                 int'($urandom % 16), ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
